// File: rtl/tx_block_sequencer.sv
// Transmit 64b/66b block sequencer: classifies encoder blocks, walks the C/D/T/E
// state machine and replaces illegal blocks with EBLOCK, counting them.
module tx_block_sequencer (
    input  logic        i_txc,
    input  logic        i_reset,
    input  logic        i_init_done,
    input  logic [65:0] i_txd,
    input  logic        i_tx_valid,
    output logic [65:0] o_txd,
    output logic        o_tx_valid,
    output logic [2:0]  o_state,
    output logic [15:0] o_err_count
);

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StC    = 3'd1,
        StD    = 3'd2,
        StT    = 3'd3,
        StE    = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        BlkD,
        BlkC,
        BlkS,
        BlkT,
        BlkE
    } blk_e;

    localparam logic [65:0] LBlock = {2'b01, 64'h0000_0000_0100_004b};
    localparam logic [65:0] EBlock = {2'b01, {8{7'h1e}}, 8'h1e};

    state_e      state_q, state_d;
    logic [65:0] txd_q, txd_d;
    logic        valid_q;
    logic [15:0] cnt_q, cnt_d;
    blk_e        blk_type;

    always_comb begin
        blk_type = BlkE;
        unique case (i_txd[65:64])
            2'b10: blk_type = BlkD;
            2'b01: begin
                case (i_txd[7:0])
                    8'h1e, 8'h2d, 8'h4b, 8'h55: blk_type = BlkC;
                    8'h33, 8'h66, 8'h78:        blk_type = BlkS;
                    8'h87, 8'h99, 8'haa, 8'hb4,
                    8'hcc, 8'hd2, 8'he1, 8'hff: blk_type = BlkT;
                    default:                    blk_type = BlkE;
                endcase
            end
            default: blk_type = BlkE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        if (!i_init_done) begin
            // Loss of init wins over classification and never counts as an error.
            state_d = StInit;
            txd_d   = LBlock;
        end else if (i_tx_valid) begin
            unique case (state_q)
                StInit, StC, StT: begin
                    if (blk_type == BlkC)      state_d = StC;
                    else if (blk_type == BlkS) state_d = StD;
                    else                       state_d = StE;
                end
                StD: begin
                    if (blk_type == BlkD)      state_d = StD;
                    else if (blk_type == BlkT) state_d = StT;
                    else                       state_d = StE;
                end
                StE: begin
                    if (blk_type == BlkD)      state_d = StD;
                    else if (blk_type == BlkT) state_d = StT;
                    else if (blk_type == BlkC) state_d = StC;
                    else                       state_d = StE;
                end
                default: state_d = StInit;
            endcase
            if (state_d == StE) begin
                txd_d = EBlock;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else begin
                txd_d = i_txd;
            end
        end
    end

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            state_q <= StInit;
            txd_q   <= LBlock;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            valid_q <= i_tx_valid;
            cnt_q   <= cnt_d;
        end
    end

    assign o_txd       = txd_q;
    assign o_tx_valid  = valid_q;
    assign o_state     = state_q;
    assign o_err_count = cnt_q;

endmodule

// File: doc/tx_block_sequencer.md
TX_BLOCK_SEQUENCER -- requirements
Module: tx_block_sequencer

Interface
REQ-001 SHALL have port i_txc, input, 1 bit: the only clock; all logic on its rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_init_done, input, 1 bit: PCS initialised; low forces the INIT state.
REQ-004 SHALL have port i_txd, input, 66 bits: encoded block from the encoder; [65:64] is the sync header (2'b10 data, 2'b01 control); [63:0] is the payload, LSB first; [7:0] is the block type.
REQ-005 SHALL have port i_tx_valid, input, 1 bit: i_txd is valid this cycle; low is a gearbox pause.
REQ-006 SHALL have port o_txd, output, 66 bits: sequenced block, in the same format as i_txd.
REQ-007 SHALL have port o_tx_valid, output, 1 bit: o_txd is valid.
REQ-008 SHALL have port o_state, output, 3 bits: current state; INIT=0, C=1, D=2, T=3, E=4.
REQ-009 SHALL have port o_err_count, output, 16 bits: number of blocks replaced by EBLOCK, saturating.

Function
REQ-010 SHALL classify each valid i_txd combinationally into type D, C, S, T or E, as follows:
- header 2'b10 → D.
- header 2'b01 with type 8'h1e, 8'h2d, 8'h4b or 8'h55 → C.
- header 2'b01 with type 8'h33, 8'h66 or 8'h78 → S.
- header 2'b01 with type 8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1 or 8'hff → T.
- any other type, or header 2'b00/2'b11 → E.
REQ-011 SHALL run a state machine with states INIT, C, D, T and E, and SHALL advance it only on cycles with i_tx_valid=1.
REQ-012 SHALL use these transitions when i_init_done=1:
- INIT, C, T: C→C, S→D, otherwise →E.
- D: D→D, T→T, otherwise →E.
- E: D→D, T→T, C→C, otherwise →E (S→E).
REQ-013 SHALL, when i_init_done=0, force the next state to INIT regardless of i_tx_valid, and SHALL drive o_txd=LBLOCK with o_tx_valid equal to i_tx_valid.
REQ-014 SHALL define LBLOCK as header 2'b01 with payload 64'h0000_0000_0100_004b (local-fault ordered set).
REQ-015 SHALL define EBLOCK as header 2'b01, [7:0]=8'h1e, and each 7-bit field [8+7k +: 7] (k=0..7) equal to 7'h1e.
REQ-016 SHALL register o_txd one cycle after the valid input:
- i_txd when the next state is C, D or T;
- EBLOCK when the next state is E.
REQ-017 SHALL set o_tx_valid to i_tx_valid registered by one cycle.
REQ-018 SHALL hold o_txd and the state when i_tx_valid=0, with o_tx_valid=0 on the following cycle.
REQ-019 SHALL increment o_err_count by 1 for each valid block whose next state is E while i_init_done=1, and SHALL saturate it at 16'hFFFF.
REQ-020 SHALL give an i_init_done deassertion mid-frame priority over classification: the next state is INIT and the error count does not increment.
REQ-021 SHALL update o_state as a registered value, in the same cycle as o_txd.

Reset
REQ-022 SHALL, on i_reset=1 at a clock edge, set the state to INIT, o_txd={2'b01, LBLOCK payload}, o_tx_valid=0 and o_err_count=0.
REQ-023 SHALL give i_reset priority over all other inputs, including mid-frame and during a pause.
REQ-024 SHALL resume classification on the first valid cycle after reset is released with i_init_done=1.

Verification
REQ-025 SHALL be covered by this directed scenario: reset, i_init_done=1, then valid idle blocks (01, type 1e) → o_state=C and o_txd equals the input one cycle later.
REQ-026 SHALL be covered by this directed scenario: sequence C, S(78), D, D, T(87), C → states C, D, D, D, T, C, o_txd=i_txd delayed by 1 cycle, o_err_count=0.
REQ-027 SHALL be covered by this directed scenario: D block while in C → o_state=E, o_txd=EBLOCK, o_err_count=1; then T(ff) → o_state=T, o_txd=input.
REQ-028 SHALL be covered by this directed scenario: header 2'b11 in D, and S(33) while in D → both replaced by EBLOCK, o_err_count increases by 2.
REQ-029 SHALL be covered by this directed scenario: i_tx_valid=0 for 3 cycles mid-frame → o_tx_valid=0, state and o_txd held, no count change; the frame then completes normally.
REQ-030 SHALL be covered by this directed scenario: i_init_done dropped mid-frame → next o_txd=LBLOCK, o_state=INIT, count unchanged; force 65535 errors then one more → o_err_count stays 16'hFFFF.
